// File: rtl/mul_div_ctrl_pkg.sv
// rtl/mul_div_ctrl_pkg.sv - shared types and constants for the multiply/divide unit
package mul_div_ctrl_pkg;

    typedef enum logic [2:0] {
        MULf    = 3'd0,
        MULHf   = 3'd1,
        MULHSUf = 3'd2,
        MULHUf  = 3'd3,
        DIVf    = 3'd4,
        DIVUf   = 3'd5,
        REMf    = 3'd6,
        REMUf   = 3'd7
    } MUL_DIV_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_t;

    localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/mul_div_ctrl_div_step.sv
// rtl/mul_div_ctrl_div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            dividend_bit,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    // rem_in < divisor, so the top bit of diff is exactly the borrow
    assign q_bit   = ~diff[XLEN];
    assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/mul_div_ctrl.sv
// rtl/mul_div_ctrl.sv - multi-cycle RV-style multiply/divide controller
module mul_div_ctrl
    import mul_div_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t       state_q, state_d;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, quo_q, rem_q;
    logic [5:0]      cnt_q;
    logic            qneg_q, rneg_q;

    logic            accept, div_zero, div_ovf, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    assign accept      = start && !flush;
    assign div_zero    = (src_b == '0);
    assign div_ovf     = !op[0] && (src_a == INT_MIN) && (src_b == '1);
    assign a_neg       = !op[0] && src_a[XLEN-1];
    assign b_neg       = !op[0] && src_b[XLEN-1];
    assign a_mag       = a_neg ? -src_a : src_a;
    assign b_mag       = b_neg ? -src_b : src_b;
    assign special_res = div_zero ? (op[1] ? src_a : '1) : (op[1] ? '0 : INT_MIN);

    logic [2*XLEN-1:0] mul_a, mul_b, product;
    logic [XLEN-1:0]   mul_res, q_fix, r_fix, fix_res;

    assign mul_a   = (op_q == MULHf || op_q == MULHSUf) ? {{XLEN{a_q[XLEN-1]}}, a_q}
                                                        : {{XLEN{1'b0}}, a_q};
    assign mul_b   = (op_q == MULHf) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
    assign product = mul_a * mul_b;
    assign mul_res = (op_q == MULf) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    assign q_fix   = qneg_q ? -quo_q : quo_q;
    assign r_fix   = rneg_q ? -rem_q : rem_q;
    assign fix_res = op_q[1] ? r_fix : q_fix;

    logic [XLEN-1:0] step_rem;
    logic            step_q;

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in       (rem_q),
        .divisor      (b_q),
        .dividend_bit (quo_q[XLEN-1]),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = !op[2] ? MUL : ((div_zero || div_ovf) ? DONE : DIV);
            MUL:  state_d = DONE;
            DIV:  if (cnt_q == 6'd1) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // quo_q starts as the dividend magnitude and shifts quotient bits in from the bottom
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            result <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q   <= op;
                    a_q    <= src_a;
                    b_q    <= op[2] ? b_mag : src_b;
                    quo_q  <= a_mag;
                    rem_q  <= '0;
                    cnt_q  <= 6'(DIV_CYCLES);
                    qneg_q <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    if (op[2] && (div_zero || div_ovf)) result <= special_res;
                end
                MUL: if (!flush) result <= mul_res;
                DIV: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[XLEN-2:0], step_q};
                    cnt_q <= cnt_q - 6'd1;
                end
                FIX: if (!flush) result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// tb/tb_mul_div_ctrl.sv - self-checking bench for mul_div_ctrl
module tb_mul_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_div_ctrl #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint            sa, sb, ua;
        longint unsigned   pu;
        logic [63:0]       p;
        int                ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ia = a;
        ib = b;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sb < 0 ? sa * (sb + 64'sh1_0000_0000) : sa * sb; return p[63:32]; end
            3'd3: begin pu = {32'd0, a}; pu = pu * {32'd0, b}; p = pu; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
        if (ua < 0) return 32'd0;
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[2]) return 2;
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Caller must be at a negedge; operands are scrambled right after the start edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
        lat = -1;
        res = 'x;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] res, last_exp, ra, rb;
        logic [2:0]  ro;
        int          lat, ndone, sel;
        int          done_cyc[$];
        logic [31:0] done_res[$];

        vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 2,  "mulh_neg2x3"};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 2,  "mul_neg2x3"};
        vecs[2]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, "div_neg7_2"};
        vecs[3]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, "rem_neg7_2"};
        vecs[4]  = '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1,  "divu_by0"};
        vecs[5]  = '{3'd7, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1,  "remu_by0"};
        vecs[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf"};
        vecs[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf"};
        vecs[8]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  "mulhsu_m1"};
        vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2,  "mulhu_max"};
        vecs[10] = '{3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1,  "rem_by0"};
        vecs[11] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34, "rem_7_neg2"};
        vecs[12] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_neg2"};
        vecs[13] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 34, "divu_max_1"};

        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        last_exp = '0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check({vecs[i].name, "_result"}, 64'(res), 64'(vecs[i].exp_res));
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].exp_lat));
            last_exp = vecs[i].exp_res;
        end
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = $urandom_range(1, 15);
            else               rb = $urandom;
            @(negedge clk);
            run_op(ro, ra, rb, res, lat);
            check($sformatf("rand%0d_op%0d_result", i, ro), 64'(res), 64'(model(ro, ra, rb)));
            check($sformatf("rand%0d_op%0d_latency", i, ro), 64'(lat), 64'(exp_latency(ro, ra, rb)));
            last_exp = model(ro, ra, rb);
        end

        // flush mid-divide: no done, result untouched, then a clean retry
        @(negedge clk);
        start = 1'b1; op = 3'd5; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_result", 64'(result), 64'(last_exp));
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush_no_done", 64'(ndone), 64'd0);
        run_op(3'd5, 32'd100, 32'd7, res, lat);
        check("retry_divu_result", 64'(res), 64'd14);
        check("retry_divu_latency", 64'(lat), 64'd34);

        // flush and start together in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush_start_no_done", 64'(ndone), 64'd0);
        check("flush_start_result", 64'(result), 64'd14);

        // start held high with changing operands, then reset mid-divide
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc <= 80; cyc++) begin
            if (done) begin
                done_cyc.push_back(cyc);
                done_res.push_back(result);
            end
            op = 3'd5; src_a = 32'(1000 + cyc * 7); src_b = 32'(3 + cyc);
            if (cyc == 80) break;
            @(posedge clk);
            @(negedge clk);
        end
        check("held_start_done_count", 64'(done_cyc.size()), 64'd2);
        if (done_cyc.size() == 2) begin
            check("held_first_cycle", 64'(done_cyc[0]), 64'd34);
            check("held_first_result", 64'(done_res[0]), 64'(32'd1000 / 32'd3));
            check("held_second_cycle", 64'(done_cyc[1]), 64'd69);
            check("held_second_result", 64'(done_res[1]), 64'(32'(1000 + 35 * 7) / 32'(3 + 35)));
        end
        check("held_third_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_done", 64'(done), 64'd0);
        check("async_reset_result", 64'(result), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("reset_no_done", 64'(ndone), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_div_ctrl.md
MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  MUL_DIV_t function code (MULf..REMUf), captured with start.
REQ-006 src_a  input  XLEN  rs1 operand (multiplicand/dividend), captured with start.
REQ-007 src_b  input  XLEN  rs2 operand (multiplier/divisor), captured with start.
REQ-008 flush  input  1  abort the in-flight operation.
REQ-009 busy  output  1  operation in progress; pipeline stall.
REQ-010 done  output  1  single-cycle pulse; result valid.
REQ-011 result  output  XLEN  operation result; holds its value until the next done.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV, FIX and DONE.
REQ-013 IDLE with start=1 SHALL capture op, src_a and src_b. The next state SHALL be:
- MUL for op[2]=0;
- DONE for a divide by zero or signed overflow;
- DIV otherwise.
REQ-014 MUL SHALL compute the full 2*XLEN product from operands sign-extended per op, then go to DONE.
- MULf: low half.
- MULHf: high half, signed x signed.
- MULHSUf: high half, signed x unsigned.
- MULHUf: high half, unsigned x unsigned.
REQ-015 DIV SHALL perform restoring division on operand magnitudes, one quotient bit per cycle, for exactly XLEN cycles using a 6-bit down-counter, then go to FIX.
- Signed operands (DIVf/REMf) SHALL be converted to magnitudes.
- Unsigned operands (DIVUf/REMUf) SHALL be used as is.
REQ-016 FIX SHALL apply the sign correction, then go to DONE.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-017 Divide by zero SHALL give quotient all-ones and remainder src_a, for both signed and unsigned ops.
REQ-018 Signed overflow (src_a=0x80000000, src_b=0xFFFFFFFF, DIVf/REMf) SHALL give quotient 0x80000000 and remainder 0.
REQ-019 DIVf/DIVUf SHALL return the quotient; REMf/REMUf SHALL return the remainder.
REQ-020 DONE SHALL assert done for exactly one cycle, load result, and return to IDLE.
REQ-021 Latency, counted from the start cycle to the done cycle:
- multiply: 2 cycles;
- divide by zero or signed overflow: 1 cycle;
- normal divide: XLEN+2 cycles (34 for XLEN=32).
REQ-022 busy SHALL be high in every state except IDLE, including the DONE cycle.
REQ-023 start SHALL be ignored while busy=1; back-to-back start in the cycle after done SHALL be accepted.
REQ-024 flush in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and result unchanged.
REQ-025 flush and start together in IDLE: flush SHALL win and the request SHALL be dropped.
REQ-026 Operands SHALL be held internally, so src_a/src_b/op changes after the start cycle have no effect.

Reset
REQ-027 rst_n=0 SHALL asynchronously force: state IDLE, busy=0, done=0, result=0, counter=0, all operand and partial registers 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation with no done pulse after release.
REQ-029 The first start SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-030 The shared package SHALL hold the state enum md_state_t (IDLE, MUL, DIV, FIX, DONE) and the constant DIV_CYCLES=32; MUL_DIV_t is already there.
REQ-031 The block SHALL contain one sub-module, div_step: a combinational one-bit restoring step (remainder, divisor, next dividend bit in; new remainder and quotient bit out).
REQ-032 The block SHALL be pure RTL with no vendor multiplier or divider IP.

Verification
REQ-033 MULHf, src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> done 2 cycles after start, result=0xFFFFFFFF; MULf with the same operands -> 0xFFFFFFFA.
REQ-034 DIVf, src_a=0xFFFFFFF9 (-7), src_b=2 -> done at cycle 34, result=0xFFFFFFFD; REMf with the same operands -> 0xFFFFFFFF.
REQ-035 DIVUf, src_b=0, src_a=0x12345678 -> done at cycle 1, result=0xFFFFFFFF; REMUf with the same operands -> 0x12345678.
REQ-036 DIVf, src_a=0x80000000, src_b=0xFFFFFFFF -> result=0x80000000; REMf with the same operands -> 0.
REQ-037 DIVUf 100/7 started, flush at cycle 10 -> busy=0 next cycle, no done, result unchanged; a new start of DIVUf 100/7 -> result=14.
REQ-038 start held high continuously with new operands, plus rst_n pulsed low mid-divide:
- start is ignored while busy;
- reset clears all outputs asynchronously;
- one done per accepted operation.
